udp_app_ctrl: RTL and testbench
===============================

# udp_app_ctrl

Parametrised application-side controller for the UDP/IP/MAC stack (`udp_ip_mac_top`) on the GMII/RGMII clock. It performs startup ARP resolution with bounded retry and re-resolves on a cache miss. It serialises a wide payload word of variable byte length into the stack's byte-write interface under a valid/ready handshake. It also captures received UDP payload bytes into a wide register with length and truncation flags.

## Interface
**Parameters**
- MAX_BYTES, 160: maximum TX payload bytes; payload bus is MAX_BYTES*8 wide.
- RX_BYTES, 160: RX capture depth in bytes.
- STARTUP_CNT, 125_000_000: idle cycles after reset before the first ARP request.
- ARP_TIMEOUT, 125_000_000: cycles to wait for arp_found per request.
- ARP_RETRIES, 4: ARP requests per resolution attempt before failure.

**Ports**
- rgmii_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  payload offered.
- tx_ready  out  1  controller accepts payload this cycle.
- tx_data  in  MAX_BYTES*8  payload; byte k = bits [MAX_BYTES*8-1-8k -: 8].
- tx_len  in  16  payload byte count.
- tx_done  out  1  one-cycle pulse: frame sent (mac_send_end seen).
- tx_err  out  1  one-cycle pulse: frame rejected or dropped.
- link_up  out  1  peer MAC resolved.
- arp_req  out  1  one-cycle ARP request to stack.
- arp_found, mac_not_exist, mac_send_end  in  1  stack status.
- app_data_request  out  1  UDP send request to stack.
- udp_send_ack  in  1  stack ready for payload bytes.
- app_data_in_valid  out  1  payload byte strobe.
- app_data_in  out  8  payload byte.
- app_data_length  out  16  latched tx_len.
- udp_rec_data_valid  in  1  RX byte strobe.
- udp_rec_rdata  in  8  RX byte.
- rx_valid  out  1  one-cycle pulse: frame captured.
- rx_data  out  RX_BYTES*8  captured payload, same byte order as tx_data.
- rx_len  out  16  bytes received in the frame, saturating at 65535.
- rx_trunc  out  1  rx_len > RX_BYTES; valid with rx_valid.

## Operation
- States: IDLE, ARP_REQ, ARP_SEND, ARP_WAIT, READY, CHECK_ARP, GEN_REQ, WRITE, SEND.
- IDLE: cycle counter runs; at STARTUP_CNT-1 go to ARP_REQ, retry count = 0.
- ARP_REQ: arp_req=1 for one cycle; retry++; go to ARP_SEND.
- ARP_SEND: wait for mac_send_end, then ARP_WAIT with counter cleared.
- ARP_WAIT:
  - arp_found: link_up=1; go to CHECK_ARP if a frame is pending, else READY.
  - Counter reaches ARP_TIMEOUT-1 with retry < ARP_RETRIES: go to ARP_REQ.
  - Counter reaches ARP_TIMEOUT-1 with retries exhausted: link_up=0; pulse tx_err if a frame is pending and drop it; go to IDLE.
- READY: tx_ready=1.
  - tx_valid accepted with 1 ≤ tx_len ≤ MAX_BYTES: latch data and length, go to CHECK_ARP.
  - Any other tx_len: pulse tx_err, stay in READY.
- CHECK_ARP: mac_not_exist → link_up=0, retry=0, go to ARP_REQ, frame kept pending. Otherwise go to GEN_REQ.
- GEN_REQ: app_data_request=1; on udp_send_ack go to WRITE.
- WRITE: app_data_in_valid=1 for exactly len consecutive cycles, bytes 0..len-1 in order; then SEND.
- SEND: on mac_send_end pulse tx_done and go to READY.
- RX (independent of the TX FSM):
  - First strobe of a frame zero-fills rx_data and resets the count.
  - Byte k < RX_BYTES is stored at slot k; later bytes are counted and discarded.
  - Falling edge of udp_rec_data_valid: rx_valid pulses with rx_len and rx_trunc.
  - rx_data holds until the next frame starts.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-frame aborts immediately. No further byte strobes are issued and no tx_done/rx_valid pulses follow.
- tx_ready is combinational from state. The accept cycle is tx_valid & tx_ready. The earliest app_data_request is 2 cycles after acceptance.
- First app_data_in_valid appears the cycle after udp_send_ack is sampled. app_data_in is registered and aligned with its strobe.
- rx_valid appears 1 cycle after the last strobe. A frame starting in the same cycle as the pulse is captured correctly.
- tx_done and tx_err never assert in the same cycle.

## Structure
- Package udp_app_pkg holds the state encoding (one-hot, 9 bits), the 16-bit length type, and the counter width derived from max(STARTUP_CNT, ARP_TIMEOUT).
- Sub-module udp_rx_capture (RX_BYTES) contains the RX path. The top level holds the FSM and the serialiser.

## Test plan
- STARTUP_CNT=16, ARP_TIMEOUT=32; arp_found 5 cycles after mac_send_end → exactly one arp_req; link_up=1; tx_ready=1.
- No arp_found, ARP_RETRIES=4 → 4 arp_req pulses spaced by ARP_TIMEOUT+ARP_SEND; link_up stays 0; return to IDLE.
- tx_len=3, tx_data bytes 0xA1,0xB2,0xC3 → after udp_send_ack, 3 consecutive strobes 0xA1,0xB2,0xC3; app_data_length=3; tx_done after mac_send_end.
- tx_len=0 or tx_len=MAX_BYTES+1 → one tx_err pulse, no app_data_request. tx_len=MAX_BYTES → all bytes sent.
- mac_not_exist in CHECK_ARP → ARP re-resolution, then the same pending frame is sent unchanged.
- RX_BYTES=4; RX frame of 6 bytes 01..06 → rx_data=0x01020304, rx_len=6, rx_trunc=1. Next 2-byte frame 0xAA,0xBB → rx_data=0xAABB0000, rx_len=2, rx_trunc=0.

Source files
------------

// File: rtl/udp_app_pkg.sv
// Shared types for the UDP application controller: FSM encoding, length type
// and the ARP/startup counter width helper.
package udp_app_pkg;

  typedef enum logic [8:0] {
    S_IDLE      = 9'h001,
    S_ARP_REQ   = 9'h002,
    S_ARP_SEND  = 9'h004,
    S_ARP_WAIT  = 9'h008,
    S_READY     = 9'h010,
    S_CHECK_ARP = 9'h020,
    S_GEN_REQ   = 9'h040,
    S_WRITE     = 9'h080,
    S_SEND      = 9'h100
  } state_e;

  typedef logic [15:0] len_t;

  localparam len_t LEN_MAX = 16'hFFFF;

  // Bits needed to count 0 .. max(a,b)-1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/udp_rx_capture.sv
// Captures received UDP payload bytes into a wide register, counting the full
// frame length and flagging frames longer than the capture depth.
module udp_rx_capture
  import udp_app_pkg::*;
#(
  parameter int unsigned RX_BYTES = 160
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  udp_rec_data_valid,
  input  logic [7:0]            udp_rec_rdata,
  output logic                  rx_valid,
  output logic [RX_BYTES*8-1:0] rx_data,
  output logic [15:0]           rx_len,
  output logic                  rx_trunc
);

  localparam int unsigned DW = RX_BYTES * 8;

  logic          live_q;
  logic          in_frame_q;
  len_t          cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic          start;

  // live_q resets high so a strobe already running at reset release is
  // treated as the tail of an aborted frame, not the start of a new one.
  assign start = udp_rec_data_valid & ~live_q;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (start) begin
      data_d              = '0;
      data_d[DW-1 -: 8]   = udp_rec_rdata;
      cnt_d               = 16'd1;
    end else if (in_frame_q && udp_rec_data_valid) begin
      for (int unsigned i = 1; i < RX_BYTES; i++) begin
        if (cnt_q == len_t'(i)) data_d[DW-1-8*i -: 8] = udp_rec_rdata;
      end
      if (cnt_q != LEN_MAX) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q     <= 1'b1;
      in_frame_q <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
    end else begin
      live_q     <= udp_rec_data_valid;
      in_frame_q <= udp_rec_data_valid & (in_frame_q | start);
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

  assign rx_valid = in_frame_q & ~udp_rec_data_valid;
  assign rx_data  = data_q;
  assign rx_len   = cnt_q;
  assign rx_trunc = cnt_q > len_t'(RX_BYTES);

endmodule

// File: rtl/udp_app_ctrl.sv
// Application-side controller for the UDP/IP/MAC stack: ARP resolution with
// retry, TX payload serialisation into the byte-write interface, RX capture.
module udp_app_ctrl
  import udp_app_pkg::*;
#(
  parameter int unsigned MAX_BYTES   = 160,
  parameter int unsigned RX_BYTES    = 160,
  parameter int unsigned STARTUP_CNT = 125_000_000,
  parameter int unsigned ARP_TIMEOUT = 125_000_000,
  parameter int unsigned ARP_RETRIES = 4
) (
  input  logic                   rgmii_clk,
  input  logic                   rst,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [MAX_BYTES*8-1:0] tx_data,
  input  logic [15:0]            tx_len,
  output logic                   tx_done,
  output logic                   tx_err,
  output logic                   link_up,
  output logic                   arp_req,
  input  logic                   arp_found,
  input  logic                   mac_not_exist,
  input  logic                   mac_send_end,
  output logic                   app_data_request,
  input  logic                   udp_send_ack,
  output logic                   app_data_in_valid,
  output logic [7:0]             app_data_in,
  output logic [15:0]            app_data_length,
  input  logic                   udp_rec_data_valid,
  input  logic [7:0]             udp_rec_rdata,
  output logic                   rx_valid,
  output logic [RX_BYTES*8-1:0]  rx_data,
  output logic [15:0]            rx_len,
  output logic                   rx_trunc
);

  localparam int unsigned CW = cnt_width(STARTUP_CNT, ARP_TIMEOUT);
  localparam int unsigned RW = (ARP_RETRIES > 0) ? $clog2(ARP_RETRIES + 1) : 1;
  localparam int unsigned DW = MAX_BYTES * 8;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d;
  logic          link_q, link_d;
  logic [DW-1:0] data_q, data_d;
  len_t          len_q, len_d;
  len_t          idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;

  logic accept, len_ok, startup_hit, timeout_hit, retry_left, give_up;

  assign accept      = tx_valid & (state_q == S_READY);
  assign len_ok      = (tx_len != '0) && (tx_len <= len_t'(MAX_BYTES));
  assign startup_hit = cnt_q == CW'(STARTUP_CNT - 1);
  assign timeout_hit = cnt_q == CW'(ARP_TIMEOUT - 1);
  assign retry_left  = retry_q < RW'(ARP_RETRIES);
  assign give_up     = (state_q == S_ARP_WAIT) & ~arp_found & timeout_hit & ~retry_left;

  always_ff @(posedge rgmii_clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (startup_hit) state_d = S_ARP_REQ;
      S_ARP_REQ:   state_d = S_ARP_SEND;
      S_ARP_SEND:  if (mac_send_end) state_d = S_ARP_WAIT;
      S_ARP_WAIT: begin
        if (arp_found)        state_d = pend_q ? S_CHECK_ARP : S_READY;
        else if (timeout_hit) state_d = retry_left ? S_ARP_REQ : S_IDLE;
      end
      S_READY:     if (accept && len_ok) state_d = S_CHECK_ARP;
      S_CHECK_ARP: state_d = mac_not_exist ? S_ARP_REQ : S_GEN_REQ;
      S_GEN_REQ:   if (udp_send_ack) state_d = S_WRITE;
      S_WRITE:     if (idx_q == len_q) state_d = S_SEND;
      S_SEND:      if (mac_send_end) state_d = S_READY;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready          = state_q == S_READY;
    arp_req           = state_q == S_ARP_REQ;
    app_data_request  = state_q == S_GEN_REQ;
    app_data_in_valid = state_q == S_WRITE;
    tx_done           = (state_q == S_SEND) & mac_send_end;
    tx_err            = (accept & ~len_ok) | (give_up & pend_q);
  end

  // The payload is shifted out MSB-first so byte k never needs a variable index.
  always_comb begin
    cnt_d   = '0;
    retry_d = retry_q;
    pend_d  = pend_q;
    link_d  = link_q;
    data_d  = data_q;
    len_d   = len_q;
    idx_d   = idx_q;
    byte_d  = byte_q;
    if ((state_d == state_q) && (state_q == S_IDLE || state_q == S_ARP_WAIT))
      cnt_d = cnt_q + CW'(1);
    case (state_q)
      S_IDLE:      if (startup_hit) retry_d = '0;
      S_ARP_REQ:   retry_d = retry_q + RW'(1);
      S_ARP_WAIT: begin
        if (arp_found) link_d = 1'b1;
        else if (give_up) begin
          link_d = 1'b0;
          pend_d = 1'b0;
        end
      end
      S_READY: begin
        if (accept && len_ok) begin
          pend_d = 1'b1;
          data_d = tx_data;
          len_d  = tx_len;
        end
      end
      S_CHECK_ARP: begin
        if (mac_not_exist) begin
          link_d  = 1'b0;
          retry_d = '0;
        end
      end
      S_GEN_REQ: begin
        if (udp_send_ack) begin
          byte_d = data_q[DW-1 -: 8];
          data_d = data_q << 8;
          idx_d  = 16'd1;
        end
      end
      S_WRITE: begin
        byte_d = data_q[DW-1 -: 8];
        data_d = data_q << 8;
        idx_d  = idx_q + 16'd1;
      end
      S_SEND:      if (mac_send_end) pend_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge rgmii_clk) begin
    if (rst) begin
      cnt_q   <= '0;
      retry_q <= '0;
      pend_q  <= 1'b0;
      link_q  <= 1'b0;
      data_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pend_q  <= pend_d;
      link_q  <= link_d;
      data_q  <= data_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
    end
  end

  assign link_up         = link_q;
  assign app_data_in     = byte_q;
  assign app_data_length = len_q;

  udp_rx_capture #(
    .RX_BYTES(RX_BYTES)
  ) u_rx (
    .clk                (rgmii_clk),
    .rst                (rst),
    .udp_rec_data_valid (udp_rec_data_valid),
    .udp_rec_rdata      (udp_rec_rdata),
    .rx_valid           (rx_valid),
    .rx_data            (rx_data),
    .rx_len             (rx_len),
    .rx_trunc           (rx_trunc)
  );

endmodule

// File: tb/tb_udp_app_ctrl.sv
// Scoreboard bench for udp_app_ctrl: directed TX/RX/ARP vectors, expectations
// queued at stimulus time and checked by independent monitors.
module tb_udp_app_ctrl;

  localparam int unsigned MB = 8;
  localparam int unsigned RB = 4;
  localparam int unsigned SC = 16;
  localparam int unsigned AT = 32;
  localparam int unsigned AR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid, tx_ready, tx_done, tx_err, link_up, arp_req;
  logic [MB*8-1:0] tx_data;
  logic [15:0]   tx_len, app_data_length, rx_len;
  logic          arp_found, mac_not_exist, mac_send_end;
  logic          app_data_request, udp_send_ack, app_data_in_valid;
  logic [7:0]    app_data_in, udp_rec_rdata;
  logic          udp_rec_data_valid, rx_valid, rx_trunc;
  logic [RB*8-1:0] rx_data;

  always #4 clk = ~clk;

  udp_app_ctrl #(
    .MAX_BYTES(MB), .RX_BYTES(RB), .STARTUP_CNT(SC), .ARP_TIMEOUT(AT), .ARP_RETRIES(AR)
  ) dut (
    .rgmii_clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_len(tx_len),
    .tx_done(tx_done), .tx_err(tx_err), .link_up(link_up), .arp_req(arp_req),
    .arp_found(arp_found), .mac_not_exist(mac_not_exist), .mac_send_end(mac_send_end),
    .app_data_request(app_data_request), .udp_send_ack(udp_send_ack),
    .app_data_in_valid(app_data_in_valid), .app_data_in(app_data_in),
    .app_data_length(app_data_length),
    .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_len(rx_len), .rx_trunc(rx_trunc)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct { logic [7:0] b; logic [15:0] len; } txb_t;
  typedef struct { logic [31:0] d; logic [15:0] len; logic tr; } rxe_t;
  txb_t        txq[$];
  int          evq[$];          // 1 = tx_done, 2 = tx_err
  rxe_t        rxq[$];
  int unsigned arp_cyc[$];
  int unsigned req_cnt = 0;

  // ---------------- monitor ----------------
  logic        mon_req_prev = 1'b0, mon_v_prev = 1'b0;
  int unsigned run = 0, run_len = 0, last_rx = 0;
  txb_t        tb_e;
  rxe_t        rb_e;
  int          got_ev;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (arp_req) arp_cyc.push_back(cyc);
        if (app_data_request && !mon_req_prev) req_cnt++;
        mon_req_prev = app_data_request;

        if (app_data_in_valid) begin
          check("tx_byte_expected", 64'(txq.size() != 0), 64'd1);
          if (txq.size() != 0) begin
            tb_e = txq.pop_front();
            check("tx_byte", 64'(app_data_in), 64'(tb_e.b));
            check("tx_app_len", 64'(app_data_length), 64'(tb_e.len));
            run_len = tb_e.len;
          end
          run++;
        end else if (mon_v_prev) begin
          check("tx_strobe_run", 64'(run), 64'(run_len));
          run = 0;
        end
        mon_v_prev = app_data_in_valid;

        if (tx_done || tx_err) begin
          check("done_err_exclusive", 64'(tx_done & tx_err), 64'd0);
          got_ev = tx_done ? 1 : 2;
          check("tx_event_expected", 64'(evq.size() != 0), 64'd1);
          if (evq.size() != 0) check("tx_event", 64'(got_ev), 64'(evq.pop_front()));
        end

        if (rx_valid) begin
          check("rx_latency", 64'(cyc), 64'(last_rx + 1));
          check("rx_expected", 64'(rxq.size() != 0), 64'd1);
          if (rxq.size() != 0) begin
            rb_e = rxq.pop_front();
            check("rx_data", 64'(rx_data), 64'(rb_e.d));
            check("rx_len", 64'(rx_len), 64'(rb_e.len));
            check("rx_trunc", 64'(rx_trunc), 64'(rb_e.tr));
          end
        end
        if (udp_rec_data_valid) last_rx = cyc;
      end
    end
  end

  // ---------------- stack model ----------------
  bit   arp_ok = 1'b0;
  int   ms_cd = -1, af_cd = -1, ack_cd = -1;
  logic mdl_v_prev = 1'b0;

  initial begin
    mac_send_end = 1'b0; arp_found = 1'b0; udp_send_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      mac_send_end = 1'b0; arp_found = 1'b0; udp_send_ack = 1'b0;
      if (rst) begin
        ms_cd = -1; af_cd = -1; ack_cd = -1; mdl_v_prev = 1'b0;
      end else begin
        if (ms_cd == 0)  mac_send_end = 1'b1;
        if (ms_cd >= 0)  ms_cd--;
        if (af_cd == 0)  arp_found = 1'b1;
        if (af_cd >= 0)  af_cd--;
        if (ack_cd == 0) udp_send_ack = 1'b1;
        if (ack_cd >= 0) ack_cd--;
        if (arp_req) begin
          ms_cd = 1;
          if (arp_ok) af_cd = 6;
        end
        if (app_data_request && !udp_send_ack && ack_cd < 0) ack_cd = 1;
        if (mdl_v_prev && !app_data_in_valid) ms_cd = 1;
        mdl_v_prev = app_data_in_valid;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [63:0] data, input logic [15:0] len, input bit good);
    int n;
    if (good) for (int k = 0; k < int'(len); k++) txq.push_back('{data[63-8*k -: 8], len});
    evq.push_back(good ? 1 : 2);
    @(posedge clk); #1;
    tx_valid = 1'b1; tx_data = data; tx_len = len;
    @(negedge clk);
    n = 0;
    while (!tx_ready && n < 500) begin @(negedge clk); n++; end
    check("tx_accept_in_time", 64'(tx_ready), 64'd1);
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((evq.size() != 0 || txq.size() != 0) && n < 1000) begin @(negedge clk); n++; end
    check("tx_drain", 64'(evq.size() + txq.size()), 64'd0);
  endtask

  task automatic rx_send(input logic [47:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      udp_rec_data_valid = 1'b1; udp_rec_rdata = bytes[47-8*i -: 8];
    end
    @(posedge clk); #1;
    udp_rec_data_valid = 1'b0;
  endtask

  int unsigned r0, a0;
  int          n;

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_len = '0; mac_not_exist = 1'b0;
    udp_rec_data_valid = 1'b0; udp_rec_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", 64'(tx_ready), 64'd0);
    check("rst_link_up", 64'(link_up), 64'd0);
    check("rst_arp_req", 64'(arp_req), 64'd0);
    check("rst_app_req", 64'(app_data_request), 64'd0);
    check("rst_strobe", 64'(app_data_in_valid), 64'd0);
    check("rst_app_len", 64'(app_data_length), 64'd0);
    check("rst_rx", 64'({rx_valid, rx_trunc, rx_len, rx_data}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ARP failure: AR requests, each 3 cycles of request/send plus the timeout apart
    n = 0;
    while (arp_cyc.size() < AR && n < 400) begin @(negedge clk); n++; end
    check("arp_retry_count", 64'(arp_cyc.size()), 64'(AR));
    arp_ok = 1'b1;
    for (int i = 1; i < int'(arp_cyc.size()); i++)
      check("arp_retry_spacing", 64'(arp_cyc[i] - arp_cyc[i-1]), 64'(AT + 3));
    n = 0;
    while (cyc < arp_cyc[AR-1] + 40 && n < 100) begin @(negedge clk); n++; end
    check("give_up_link", 64'(link_up), 64'd0);
    check("give_up_idle", 64'(tx_ready), 64'd0);
    check("give_up_no_extra_arp", 64'(arp_cyc.size()), 64'(AR));

    // Re-resolution from IDLE succeeds with a single request
    n = 0;
    while (!link_up && n < 200) begin @(negedge clk); n++; end
    check("link_up", 64'(link_up), 64'd1);
    check("arp_single_req", 64'(arp_cyc.size()), 64'(AR + 1));
    check("arp_restart_gap", 64'(arp_cyc[AR] - arp_cyc[AR-1]), 64'(AT + 3 + SC));
    check("ready_after_link", 64'(tx_ready), 64'd1);

    // TX frames
    r0 = req_cnt;
    send(64'hA1B2C30000000000, 16'd3, 1'b1);
    drain();
    check("tx3_one_request", 64'(req_cnt), 64'(r0 + 1));

    r0 = req_cnt;
    send(64'h1111111111111111, 16'd0, 1'b0);
    send(64'h2222222222222222, 16'(MB + 1), 1'b0);
    drain();
    repeat (5) @(negedge clk);
    check("bad_len_no_request", 64'(req_cnt), 64'(r0));

    send(64'h1122334455667788, 16'(MB), 1'b1);
    drain();
    send(64'h7EFFFFFFFFFFFFFF, 16'd1, 1'b1);
    drain();

    // Cache miss: re-ARP, then the held frame goes out unchanged
    r0 = req_cnt; a0 = arp_cyc.size();
    mac_not_exist = 1'b1;
    send(64'hDEADBEEF00000000, 16'd4, 1'b1);
    n = 0;
    while (arp_cyc.size() == a0 && n < 50) begin @(negedge clk); n++; end
    mac_not_exist = 1'b0;
    check("miss_arp_req", 64'(arp_cyc.size()), 64'(a0 + 1));
    check("miss_link_down", 64'(link_up), 64'd0);
    drain();
    check("miss_one_request", 64'(req_cnt), 64'(r0 + 1));
    check("miss_link_back", 64'(link_up), 64'd1);

    // RX frames, the second starting right after the first one's pulse
    rxq.push_back('{32'h01020304, 16'd6, 1'b1});
    rx_send(48'h010203040506, 6);
    rxq.push_back('{32'hAABB0000, 16'd2, 1'b0});
    rx_send(48'hAABB00000000, 2);
    rxq.push_back('{32'h11223344, 16'd4, 1'b0});
    rx_send(48'h112233440000, 4);
    rxq.push_back('{32'h5C000000, 16'd1, 1'b0});
    rx_send(48'h5C0000000000, 1);
    n = 0;
    while (rxq.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("rx_drain", 64'(rxq.size()), 64'd0);

    repeat (5) @(negedge clk);
    check("tx_queue_left", 64'(txq.size() + evq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
